get_fifo: RTL and testbench

GET_FIFO -- requirements
Module: get_fifo

---
 rtl/get_fifo.sv | 53 +++++
 tb/tb_get_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/get_fifo.sv
// get_fifo: show-ahead stream FIFO between a DMA AXI-stream source and the receive-enable stage.
// Pointers carry an extra wrap bit so full and empty are distinguishable with equal low bits.
module get_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  input  logic                       flush,
  output logic                       get_valid,
  output logic [DATA_W-1:0]          get_data,
  output logic                       get_last,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]     wp, rp;
  logic [DATA_W:0] mem [DEPTH];
  logic            empty, full, do_push, do_pop;
  assign empty         = wp == rp;
  assign full          = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign s_axis_tready = ~full & ~flush;
  assign do_push       = s_axis_tvalid & s_axis_tready;
  assign do_pop        = pop & ~empty & ~flush;
  assign get_valid     = ~empty;
  assign get_data      = mem[rp[AW-1:0]][DATA_W-1:0];
  assign get_last      = mem[rp[AW-1:0]][DATA_W];
  assign count         = wp - rp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      underflow <= 1'b0;
    end else if (flush) begin
      wp        <= '0;
      rp        <= '0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      if (pop && empty) underflow <= 1'b1;
    end
  end
  // Storage is deliberately unreset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end
endmodule

// File: tb/tb_get_fifo.sv
// tb_get_fifo: table vectors, directed corner sequences and random traffic against a queue model.
module tb_get_fifo;
  localparam int DW = 32;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0, tlast = 1'b0, flush = 1'b0, pop = 1'b0;
  logic          tready, gv, gl, uf;
  logic [DW-1:0] gd;
  logic [CW-1:0] count;
  int            checks = 0, errors = 0;
  logic [DW:0]   q[$];
  bit            m_uf = 1'b0;

  get_fifo #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(tready), .flush(flush), .get_valid(gv),
    .get_data(gd), .get_last(gl), .pop(pop), .count(count), .underflow(uf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          p;
    bit          f;
    int          cnt;
    bit          vld;
    bit          rdy;
    logic [31:0] hd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit v, logic [31:0] d, bit p, bit f, int cnt, bit vld, bit rdy, logic [31:0] hd);
    vec_t r;
    r.v = v; r.d = d; r.p = p; r.f = f; r.cnt = cnt; r.vld = vld; r.rdy = rdy; r.hd = hd;
    return r;
  endfunction

  task automatic cmp(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drv(bit v, logic [DW-1:0] d, bit l, bit p, bit f);
    tvalid = v; tdata = d; tlast = l; pop = p; flush = f;
  endtask

  task automatic chk_model(string tag);
    cmp({tag, ".count"}, 64'(count), 64'(q.size()));
    cmp({tag, ".valid"}, 64'(gv), 64'(q.size() != 0));
    cmp({tag, ".tready"}, 64'(tready), 64'(q.size() < D && !flush));
    cmp({tag, ".underflow"}, 64'(uf), 64'(m_uf));
    if (q.size() != 0) begin
      cmp({tag, ".data"}, 64'(gd), 64'(q[0][DW-1:0]));
      cmp({tag, ".last"}, 64'(gl), 64'(q[0][DW]));
    end
  endtask

  // Called between edges; applies the current inputs to the model at the next rising edge.
  task automatic adv();
    bit was_full, was_empty;
    was_full  = q.size() == D;
    was_empty = q.size() == 0;
    @(posedge clk);
    if (flush) begin
      q.delete();
      m_uf = 1'b0;
    end else begin
      if (pop && was_empty) m_uf = 1'b1;
      if (pop && !was_empty) void'(q.pop_front());
      if (tvalid && !was_full) q.push_back({tlast, tdata});
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < D; i++) tbl.push_back(mk(1, 32'h11 + i, 0, 0, i, i > 0, 1, 32'h11));
    tbl.push_back(mk(0, 0, 0, 0, 8, 1, 0, 32'h11));
    for (int j = 0; j < D; j++) tbl.push_back(mk(0, 0, 1, 0, 8 - j, 1, j != 0, 32'h11 + j));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < D; i++) tbl.push_back(mk(1, 32'h21 + i, 0, 0, i, i > 0, 1, 32'h21));
    tbl.push_back(mk(1, 32'h99, 1, 0, 8, 1, 0, 32'h21));
    tbl.push_back(mk(0, 0, 0, 0, 7, 1, 1, 32'h22));
    tbl.push_back(mk(0, 0, 0, 1, 7, 1, 0, 32'h22));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));

    #12;
    chk_model("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    foreach (tbl[i]) begin
      drv(tbl[i].v, tbl[i].d, 1'b0, tbl[i].p, tbl[i].f);
      @(negedge clk);
      cmp($sformatf("tbl%0d.count", i), 64'(count), 64'(tbl[i].cnt));
      cmp($sformatf("tbl%0d.valid", i), 64'(gv), 64'(tbl[i].vld));
      cmp($sformatf("tbl%0d.tready", i), 64'(tready), 64'(tbl[i].rdy));
      if (tbl[i].vld) cmp($sformatf("tbl%0d.data", i), 64'(gd), 64'(tbl[i].hd));
      adv();
    end

    for (int k = 0; k < 20; k++) begin
      drv(1, 32'h100 + k, k == 19, k > 0, 0);
      @(negedge clk);
      if (k > 0) begin
        cmp("stream.count", 64'(count), 64'd1);
        cmp("stream.data", 64'(gd), 64'(32'h100 + k - 1));
        cmp("stream.last", 64'(gl), 64'd0);
      end
      adv();
    end
    drv(0, 0, 0, 1, 0);
    @(negedge clk);
    cmp("stream.tail_data", 64'(gd), 64'h113);
    cmp("stream.tail_last", 64'(gl), 64'd1);
    adv();
    chk_model("stream.end");

    drv(0, 0, 0, 1, 0);
    @(negedge clk);
    adv();
    @(negedge clk);
    cmp("uflow.flag", 64'(uf), 64'd1);
    cmp("uflow.count", 64'(count), 64'd0);
    for (int k = 0; k < 2; k++) begin
      drv(1, 32'h55 + k, 0, 0, 0);
      @(negedge clk);
      adv();
    end
    @(negedge clk);
    cmp("uflow.sticky", 64'(uf), 64'd1);
    cmp("uflow.head", 64'(gd), 64'h55);
    drv(0, 0, 0, 0, 1);
    @(negedge clk);
    adv();
    chk_model("uflow.flushed");

    for (int k = 0; k < 5; k++) begin
      drv(1, 32'h70 + k, 0, 0, 0);
      @(negedge clk);
      adv();
    end
    drv(1, 32'h7f, 0, 1, 1);
    @(negedge clk);
    cmp("flush.tready", 64'(tready), 64'd0);
    cmp("flush.count_before", 64'(count), 64'd5);
    adv();
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("flush.count", 64'(count), 64'd0);
    cmp("flush.valid", 64'(gv), 64'd0);
    cmp("flush.underflow", 64'(uf), 64'd0);

    for (int k = 0; k < 3; k++) begin
      drv(1, 32'h30 + k, 0, 0, 0);
      @(negedge clk);
      adv();
    end
    drv(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_uf = 1'b0;
    cmp("areset.count", 64'(count), 64'd0);
    cmp("areset.valid", 64'(gv), 64'd0);
    cmp("areset.tready", 64'(tready), 64'd1);
    @(negedge clk) #2 rst_n = 1'b1;
    @(posedge clk) #1;
    drv(1, 32'hAA, 0, 0, 0);
    @(negedge clk);
    cmp("areset.no_fallthrough", 64'(gv), 64'd0);
    adv();
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("areset.head", 64'(gd), 64'hAA);
    chk_model("areset.after");
    adv();

    for (int n = 0; n < 600; n++) begin
      int push_pct, pop_pct;
      push_pct = (n / 100) % 2 == 0 ? 80 : 30;
      pop_pct  = (n / 100) % 2 == 0 ? 30 : 80;
      drv($urandom_range(0, 99) < push_pct, $urandom, $urandom_range(0, 1),
          $urandom_range(0, 99) < pop_pct, $urandom_range(0, 39) == 0);
      @(negedge clk);
      chk_model("rand");
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
